// File: rtl/nonce_sweep_controller.sv
// rtl/nonce_sweep_controller.sv - sequences the hashing core across an inclusive nonce range with a watchdog
module nonce_sweep_controller #(
    parameter int NONCE_W = 32,
    parameter int TIMEOUT = 16,
    parameter int TMR_W   = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    output logic               core_start,
    output logic [NONCE_W-1:0] core_nonce,
    input  logic               core_done,
    input  logic               core_hit,
    output logic               busy,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce,
    output logic               exhausted,
    output logic               timeout_err,
    output logic [NONCE_W:0]   attempts
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FOUND,
        S_EXHAUSTED,
        S_ERROR
    } state_t;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t             r_state, w_state_nxt;
    logic [NONCE_W-1:0] r_cur, w_cur_nxt;
    logic [NONCE_W-1:0] r_end, w_end_nxt;
    logic [TMR_W-1:0]   r_timer, w_timer_nxt;
    logic               r_found, w_found_nxt;
    logic [NONCE_W-1:0] r_found_nonce, w_found_nonce_nxt;
    logic               r_exhausted, w_exhausted_nxt;
    logic               r_timeout, w_timeout_nxt;
    logic [NONCE_W:0]   r_attempts, w_attempts_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cur         <= '0;
            r_end         <= '0;
            r_timer       <= '0;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            r_exhausted   <= 1'b0;
            r_timeout     <= 1'b0;
            r_attempts    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cur         <= w_cur_nxt;
            r_end         <= w_end_nxt;
            r_timer       <= w_timer_nxt;
            r_found       <= w_found_nxt;
            r_found_nonce <= w_found_nonce_nxt;
            r_exhausted   <= w_exhausted_nxt;
            r_timeout     <= w_timeout_nxt;
            r_attempts    <= w_attempts_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cur_nxt         = r_cur;
        w_end_nxt         = r_end;
        w_timer_nxt       = r_timer;
        w_found_nxt       = r_found;
        w_found_nonce_nxt = r_found_nonce;
        w_exhausted_nxt   = r_exhausted;
        w_timeout_nxt     = r_timeout;
        w_attempts_nxt    = r_attempts;
        case (r_state)
            S_ISSUE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_timer_nxt = '0;
                end
            end
            S_WAIT: begin
                // A hit outranks a concurrent stop; a plain miss does not.
                if (core_done && core_hit) begin
                    w_state_nxt       = S_FOUND;
                    w_found_nxt       = 1'b1;
                    w_found_nonce_nxt = r_cur;
                    w_attempts_nxt    = r_attempts + 1'b1;
                end else if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (core_done) begin
                    w_attempts_nxt = r_attempts + 1'b1;
                    if (r_cur == r_end) begin
                        w_state_nxt     = S_EXHAUSTED;
                        w_exhausted_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_cur_nxt   = r_cur + 1'b1;
                    end
                end else if (r_timer == TMR_LAST) begin
                    w_state_nxt   = S_ERROR;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                if (start) begin
                    w_found_nxt     = 1'b0;
                    w_exhausted_nxt = 1'b0;
                    w_timeout_nxt   = 1'b0;
                    w_attempts_nxt  = '0;
                    w_cur_nxt       = nonce_start;
                    w_end_nxt       = nonce_end;
                    if (nonce_start > nonce_end) begin
                        w_state_nxt     = S_EXHAUSTED;
                        w_exhausted_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
        endcase
    end

    assign core_start  = (r_state == S_ISSUE);
    assign busy        = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign core_nonce  = r_cur;
    assign found       = r_found;
    assign found_nonce = r_found_nonce;
    assign exhausted   = r_exhausted;
    assign timeout_err = r_timeout;
    assign attempts    = r_attempts;

endmodule

// File: tb/tb_nonce_sweep_controller.sv
// tb/tb_nonce_sweep_controller.sv - randomized and directed checks of nonce_sweep_controller against a sweep model
module tb_nonce_sweep_controller;

    localparam int TIMEOUT = 16;

    logic        clock, reset, start, stop, core_done, core_hit;
    logic [31:0] nonce_start, nonce_end;
    logic        core_start, busy, found, exhausted, timeout_err;
    logic [31:0] core_nonce, found_nonce;
    logic [32:0] attempts;

    nonce_sweep_controller #(.NONCE_W(32), .TIMEOUT(TIMEOUT), .TMR_W(5)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .nonce_start(nonce_start), .nonce_end(nonce_end),
        .core_start(core_start), .core_nonce(core_nonce),
        .core_done(core_done), .core_hit(core_hit),
        .busy(busy), .found(found), .found_nonce(found_nonce),
        .exhausted(exhausted), .timeout_err(timeout_err), .attempts(attempts)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    bit cmp_en = 0;
    bit watch_zero = 0;
    bit zero_seen = 0;

    // Sweep model: a sweep is either running (one pass being issued or awaited) or not.
    bit          m_active, m_issue, m_found, m_exh, m_to;
    int          m_waited;
    logic [31:0] m_cur, m_end, m_fnonce;
    logic [32:0] m_att;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, s, p, input logic [31:0] ns, ne, input bit c, h);
        if (r) begin
            m_active = 0; m_issue = 0; m_found = 0; m_exh = 0; m_to = 0;
            m_waited = 0; m_cur = 0; m_end = 0; m_fnonce = 0; m_att = 0;
        end else if (!m_active) begin
            if (s) begin
                m_found = 0; m_exh = 0; m_to = 0; m_att = 0;
                m_cur = ns; m_end = ne;
                if (ns > ne) m_exh = 1;
                else begin m_active = 1; m_issue = 1; end
            end
        end else if (m_issue) begin
            m_issue = 0;
            if (p) m_active = 0;
            else m_waited = 0;
        end else begin
            if (c && h) begin
                m_found = 1; m_fnonce = m_cur; m_att = m_att + 1; m_active = 0;
            end else if (p) begin
                m_active = 0;
            end else if (c) begin
                m_att = m_att + 1;
                if (m_cur == m_end) begin m_exh = 1; m_active = 0; end
                else begin m_cur = m_cur + 1; m_issue = 1; end
            end else if (m_waited == TIMEOUT - 1) begin
                m_to = 1; m_active = 0;
            end else begin
                m_waited++;
            end
        end
    endtask

    task automatic step(input bit r, s, p, input logic [31:0] ns, ne, input bit c, h);
        reset = r; start = s; stop = p; nonce_start = ns; nonce_end = ne;
        core_done = c; core_hit = h;
        @(posedge clock);
        model_update(r, s, p, ns, ne, c, h);
        #1;
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("core_start", core_start, m_issue);
            chk("core_nonce", core_nonce, m_cur);
            chk("busy", busy, m_active);
            chk("found", found, m_found);
            chk("found_nonce", found_nonce, m_fnonce);
            chk("exhausted", exhausted, m_exh);
            chk("timeout_err", timeout_err, m_to);
            chk("attempts", attempts, m_att);
            if (core_start) pulses++;
            if (watch_zero && core_nonce == 32'h0) zero_seen = 1;
        end
    end

    initial begin
        bit          slow;
        logic [31:0] ns, ne;
        step(1, 0, 0, 0, 0, 0, 0);
        cmp_en = 1;
        step(1, 0, 0, 0, 0, 0, 0);
        chk("reset_busy", busy, 0);
        chk("reset_attempts", attempts, 0);
        chk("reset_core_nonce", core_nonce, 0);

        // Hit on the third nonce of 0x100..0x1FF.
        pulses = 0;
        step(0, 1, 0, 32'h100, 32'h1FF, 0, 0);
        chk("latency_core_start", core_start, 1);
        for (int i = 0; i < 20 && !m_found; i++) step(0, 0, 0, 0, 0, 1, m_cur == 32'h102);
        chk("hit_found", found, 1);
        chk("hit_nonce", found_nonce, 32'h102);
        chk("hit_attempts", attempts, 3);
        chk("hit_pulses", pulses, 3);

        // Exhaust 0x10..0x13.
        pulses = 0;
        step(0, 1, 0, 32'h10, 32'h13, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 1, 0);
        chk("exh_flag", exhausted, 1);
        chk("exh_attempts", attempts, 4);
        chk("exh_last_nonce", core_nonce, 32'h13);
        chk("exh_pulses", pulses, 4);

        // Top of range must not wrap.
        pulses = 0;
        step(0, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        zero_seen = 0; watch_zero = 1;
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 1, 0);
        watch_zero = 0;
        chk("top_exh", exhausted, 1);
        chk("top_attempts", attempts, 1);
        chk("top_pulses", pulses, 1);
        chk("top_no_wrap", zero_seen, 0);

        // Inverted range.
        pulses = 0;
        step(0, 1, 0, 5, 4, 0, 0);
        chk("inv_exh", exhausted, 1);
        chk("inv_attempts", attempts, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 1);
        chk("inv_pulses", pulses, 0);

        // Watchdog: 16 cycles after WAIT entry.
        step(0, 1, 0, 0, 3, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            if (i == 15) chk("wdog_not_yet", timeout_err, 0);
            if (i == 16) chk("wdog_fired", timeout_err, 1);
        end

        // Races.
        step(0, 1, 0, 0, 9, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, 1);
        chk("race_hit_found", found, 1);
        chk("race_hit_busy", busy, 0);
        step(0, 1, 0, 7, 9, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, 0);
        chk("race_stop_busy", busy, 0);
        chk("race_stop_found", found, 0);
        chk("race_stop_attempts", attempts, 0);
        step(0, 1, 0, 7, 9, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 1, 1);
        chk("rst_core_nonce", core_nonce, 0);
        chk("rst_busy", busy, 0);
        chk("rst_attempts", attempts, 0);

        // Randomized traffic against the model.
        slow = 0;
        for (int n = 0; n < 4000; n++) begin
            if (n % 400 == 0) slow = ~slow;
            ns = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom_range(0, 15);
            ne = ($urandom_range(0, 3) == 0) ? ns - 1 : ns + $urandom_range(0, 5);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                 ns, ne, slow ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 7) == 0);
        end

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
